pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, carry-chunked pipelined adder/subtractor; the multi-bit, registered successor to the single-bit full adder.
- Splits WIDTH-bit operands into CHUNK-bit slices, adds one slice per stage, and registers the carry between stages.
- Valid/ready handshake on input and output, with full-pipeline stall on backpressure.
- Sits in datapaths that need a wide add at high clock rate with one result per cycle.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- c_out  output  1  carry-out (add) / not-borrow (sub)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Arithmetic:
  - b_eff = b XOR {WIDTH{sub}}; cin_eff = c_in XOR sub.
  - {c_out, sum} = a + b_eff + cin_eff, in WIDTH+1 bits.
  - Add: a+b+c_in. Sub: a−b−c_in, with c_out=1 meaning no borrow.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Transfer rules:
  - Input handshake: accepted when in_valid && in_ready.
  - Output handshake: consumed when out_valid && out_ready.
- Pipeline structure:
  - Stage k (0..STAGES−1) adds slice k of a and b_eff plus the carry from stage k−1; stage 0 uses cin_eff.
  - Slices not yet added are carried forward in skew registers.
  - Completed low slices are carried forward in de-skew registers, so all sum slices emerge aligned.
- Latency: exactly STAGES cycles from acceptance to out_valid when not stalled. Throughput: one result per cycle.
- Per-stage valid bit; out_valid = valid bit of the final stage.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall, i.e. combinational from out_ready and the out_valid register.
  - During stall every stage register and valid bit holds; sum/c_out/ovf stay stable; no transaction is dropped or duplicated.
- Bubbles propagate normally when not stalled (empty stages advance; valid=0 slots carry no data obligation).
- Order: results leave in acceptance order.
- in_valid low: no effect on the operand inputs' relevance; a, b, c_in, sub are ignored.
- Reset (rst=1 at rising edge):
  - All valid bits cleared; out_valid=0.
  - sum=0, c_out=0, ovf=0; all skew/carry registers cleared.
  - in_ready=1 in the cycle after reset releases.
  - Reset mid-operation discards every in-flight transaction; nothing is emitted for them.
  - Reset has priority over handshake in the same cycle.
- Simultaneous events: with the pipe full and out_ready=1, output consumption and input acceptance occur in the same cycle.
- STAGES=1: degenerates to a single registered adder with latency 1; same handshake rules.
- Elaboration check: WIDTH % CHUNK != 0 or CHUNK < 1 is a compile-time error.

Test Plan:
1. WIDTH=32, CHUNK=8, out_ready=1: a=0xFFFFFFFF, b=0x00000001, c_in=0, sub=0 accepted at cycle T -> at T+4 out_valid=1, sum=0x00000000, c_out=1, ovf=0 (carry ripples through all 4 stages).
2. a=0x7FFFFFFF, b=0x00000001, add -> sum=0x80000000, c_out=0, ovf=1. Then a=0x80000000, b=0x80000000 -> sum=0x00000000, c_out=1, ovf=1.
3. Subtract: a=5, b=7, c_in=0, sub=1 -> sum=0xFFFFFFFE, c_out=0, ovf=0. a=7, b=5, c_in=1, sub=1 -> sum=0x00000001, c_out=1, ovf=0.
4. Backpressure:
   - Stimulus: drive 6 back-to-back transactions with operand pairs (i, 100·i), i=1..6; hold out_ready=0 from the first out_valid for 3 cycles, then release.
   - Required response: in_ready=0 exactly while stalled; sum held constant during the stall; all 6 results (101·i) delivered in order with none lost or duplicated.
5. Reset mid-flight:
   - Stimulus: accept 3 transactions, assert rst for 1 cycle 2 cycles later.
   - Required response: out_valid=0 and sum=0 after reset; none of the 3 results ever appear; a new transaction 10+20 yields sum=30 exactly 4 cycles after acceptance.
6. Parameter sweep (WIDTH,CHUNK) = (8,8), (16,4), (32,8), (64,16):
   - 1000 random transactions with random in_valid/out_ready/sub/c_in.
   - Scoreboard against the WIDTH+1-bit arithmetic model; latency equals STAGES whenever there is no stall.

Source files
------------

// File: rtl/pipelined_adder.sv
// Carry-chunked pipelined adder/subtractor: one CHUNK-bit slice is added per stage,
// the inter-slice carry is registered, and a valid/ready handshake stalls the whole pipe.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic              stall;

    // Stage registers. acc_q[k] holds finished sum slices 0..k in its low bits and the
    // not-yet-added slices of a above them; bop_q[k] forwards b_eff for the upper slices.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  acc_q [STAGES];
    logic [WIDTH-1:0]  bop_q [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] valid_in;
    logic [STAGES-1:0] carry_in;
    logic [WIDTH-1:0]  acc_in    [STAGES];
    logic [WIDTH-1:0]  bop_in    [STAGES];
    logic [WIDTH-1:0]  acc_next  [STAGES];
    logic [CHUNK:0]    slice_sum [STAGES];
    logic              ovf_next;

    assign b_eff   = b ^ {WIDTH{sub}};
    assign cin_eff = c_in ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
        if (k == 0) begin : g_head
            assign valid_in[k] = in_valid;
            assign carry_in[k] = cin_eff;
            assign acc_in[k]   = a;
            assign bop_in[k]   = b_eff;
        end else begin : g_link
            assign valid_in[k] = valid_q[k-1];
            assign carry_in[k] = carry_q[k-1];
            assign acc_in[k]   = acc_q[k-1];
            assign bop_in[k]   = bop_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, acc_in[k][k*CHUNK +: CHUNK]}
                         + {1'b0, bop_in[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, carry_in[k]};
            acc_next[k]  = acc_in[k];
            acc_next[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
        end
        // Sign overflow needs the operand MSBs, which only meet the sum MSB in the last stage.
        ovf_next = (acc_in[STAGES-1][WIDTH-1] == bop_in[STAGES-1][WIDTH-1])
                && (slice_sum[STAGES-1][CHUNK-1] != acc_in[STAGES-1][WIDTH-1]);
    end

    // NOTE: state registers use non-blocking assignments so every stage samples the
    // previous stage's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k] <= '0;
                bop_q[k] <= '0;
            end
        end else if (!stall) begin
            // Bubbles advance too; their data is don't-care because valid travels alongside.
            valid_q <= valid_in;
            ovf_q   <= ovf_next;
            for (int k = 0; k < STAGES; k++) begin
                carry_q[k] <= slice_sum[k][CHUNK];
                acc_q[k]   <= acc_next[k];
                bop_q[k]   <= bop_in[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign sum       = acc_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
